// File: rtl/scmp_bus_adapter_pkg.sv
// Shared types and constants for the scmp bus adapter: FSM encoding, flag
// bit positions inside bus_flags, and the read data returned on an aborted request.
package scmp_bus_pak;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      REQ  = 3'd3,
      DONE = 3'd4
   } BUS_ST_t;

   localparam int FLG_IX_R = 0;
   localparam int FLG_IX_I = 1;
   localparam int FLG_IX_D = 2;
   localparam int FLG_IX_H = 3;

   localparam logic [7:0] BUS_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/reg8.sv
// 8-bit load-enable register with asynchronous active-low clear.
module reg8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [7:0] i_d,
   output logic [7:0] o_q
);

   logic [7:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/scmp_bus_timer.sv
// Loadable down-counter that saturates at zero; o_term flags the zero count.
module scmp_bus_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_term
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_count <= '0;
      else if (i_load)                     r_count <= i_load_val;
      else if (i_en && (r_count != '0))    r_count <= r_count - 1'b1;
   end

   assign o_term = (r_count == '0);

endmodule

// File: rtl/scmp_bus_adapter.sv
// Demultiplexes the scmp core's 8-bit data / 12-bit address bus into a flat
// 16-bit memory request with a valid/ready handshake and a core stall.
module scmp_bus_adapter
   import scmp_bus_pak::*;
#(
   parameter int TIMEOUT  = 255,
   parameter int MIN_WAIT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] core_addr,
   input  logic [7:0]  core_d_o,
   input  logic        core_ads_n,
   input  logic        core_rd_n,
   input  logic        core_wr_n,
   output logic [7:0]  core_d_i,
   output logic        core_hold,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ready,
   input  logic [7:0]  mem_rdata,
   output logic [3:0]  bus_flags,
   output logic        bus_err,
   output logic [2:0]  dbg_state
);

   localparam int              TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   REQ_LD  = TW'(TIMEOUT - 1);
   localparam logic [3:0]      WAIT_LD = (MIN_WAIT > 0) ? 4'(MIN_WAIT - 1) : 4'd0;

   BUS_ST_t    r_state, w_next;
   logic       r_mem_we, r_bus_err;
   logic [3:0] r_bus_flags;
   logic [7:0] w_addr_lo, w_addr_hi, w_rd_d;
   logic       w_strobe, w_ads, w_latch_addr, w_take_strobe, w_both_low;
   logic       w_xfer_done, w_abort, w_wait_term, w_req_term;
   logic       w_wait_load, w_req_load, w_wr_latch, w_rd_latch;

   // Handshake: mem_req is valid for the whole REQ state; a cycle with
   // mem_req=1 and mem_ready=1 at the rising edge completes the transfer.
   assign w_strobe      = ~core_rd_n | ~core_wr_n;
   assign w_both_low    = ~core_rd_n & ~core_wr_n;
   assign w_ads         = ~core_ads_n;
   assign w_latch_addr  = w_ads && (r_state == IDLE || r_state == ADDR || r_state == DONE);
   assign w_take_strobe = (r_state == ADDR) && !w_ads && w_strobe;
   assign w_xfer_done   = (r_state == REQ) && mem_ready;
   assign w_abort       = (r_state == REQ) && !mem_ready && w_req_term;
   assign w_wait_load   = w_take_strobe && (MIN_WAIT > 0);
   assign w_req_load    = (w_take_strobe && (MIN_WAIT == 0)) || ((r_state == WAIT) && w_wait_term);
   assign w_wr_latch    = w_take_strobe && ~core_wr_n && core_rd_n;
   assign w_rd_latch    = (w_xfer_done && !r_mem_we) || w_abort;
   assign w_rd_d        = w_abort ? BUS_ABORT_DATA : mem_rdata;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_ads) w_next = ADDR;
         ADDR: begin
            if (w_ads)         w_next = ADDR;
            else if (w_strobe) w_next = (MIN_WAIT > 0) ? WAIT : REQ;
         end
         WAIT: if (w_wait_term) w_next = REQ;
         REQ:  if (mem_ready || w_abort) w_next = DONE;
         DONE: begin
            if (w_ads)          w_next = ADDR;
            else if (!w_strobe) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mem_we    <= 1'b0;
         r_bus_err   <= 1'b0;
         r_bus_flags <= '0;
      end else begin
         r_state <= w_next;
         if (w_take_strobe) r_mem_we <= ~core_wr_n & core_rd_n;
         if ((w_take_strobe && w_both_low) || w_abort) r_bus_err <= 1'b1;
         if (w_latch_addr) begin
            r_bus_flags[FLG_IX_H] <= core_d_o[7];
            r_bus_flags[FLG_IX_D] <= core_d_o[6];
            r_bus_flags[FLG_IX_I] <= core_d_o[5];
            r_bus_flags[FLG_IX_R] <= core_d_o[4];
         end
      end
   end

   scmp_bus_timer #(.W(4)) u_wait_tmr (
      .clk(clk), .rst_n(rst_n), .i_load(w_wait_load), .i_load_val(WAIT_LD),
      .i_en(r_state == WAIT), .o_term(w_wait_term)
   );

   scmp_bus_timer #(.W(TW)) u_req_tmr (
      .clk(clk), .rst_n(rst_n), .i_load(w_req_load), .i_load_val(REQ_LD),
      .i_en(r_state == REQ), .o_term(w_req_term)
   );

   reg8 u_addr_lo (.clk(clk), .rst_n(rst_n), .i_en(w_latch_addr),
                   .i_d(core_addr[7:0]), .o_q(w_addr_lo));
   reg8 u_addr_hi (.clk(clk), .rst_n(rst_n), .i_en(w_latch_addr),
                   .i_d({core_d_o[3:0], core_addr[11:8]}), .o_q(w_addr_hi));
   reg8 u_wdata   (.clk(clk), .rst_n(rst_n), .i_en(w_wr_latch),
                   .i_d(core_d_o), .o_q(mem_wdata));
   reg8 u_rdata   (.clk(clk), .rst_n(rst_n), .i_en(w_rd_latch),
                   .i_d(w_rd_d), .o_q(core_d_i));

   // Hold is combinational from the strobes so the core stalls in the strobe cycle itself.
   assign core_hold = ((r_state == ADDR) && w_strobe) || (r_state == WAIT) || (r_state == REQ);
   assign mem_req   = (r_state == REQ);
   assign mem_we    = r_mem_we;
   assign mem_addr  = {w_addr_hi, w_addr_lo};
   assign bus_flags = r_bus_flags;
   assign bus_err   = r_bus_err;
   assign dbg_state = r_state;

endmodule
